// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned INIT_DEPTH = 16;

  // Power-on contents of R0..R15; deeper entries reset to zero.
  localparam logic [15:0] INIT_TABLE [INIT_DEPTH] = '{
    16'h0F00, 16'h0050, 16'hFF0F, 16'hF0FF,
    16'h0040, 16'h0024, 16'h00FF, 16'hAAAA,
    16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
    16'h0002, 16'h0000, 16'h0000, 16'h0000
  };

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port with write-first bypass and zero-register masking.
module reg_file_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SPECIAL_IDX = 15,
  parameter bit          ZERO_REG0   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              gen_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sp_we,
  input  logic [DATA_W-1:0] sp_wr_data,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SPECIAL_IDX);

  logic [DATA_W-1:0] data_next;

  // Select array content, overridden by this edge's committing writes (special last).
  always_comb begin
    data_next = arr_data;
    if (gen_we && (addr == wr_addr)) data_next = wr_data;
    if (sp_we && (addr == SP_ADDR)) data_next = sp_wr_data;
    if (ZERO_REG0 && (addr == '0)) data_next = '0;
  end

  // Capture on the read strobe, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (rd_en) begin
      data <= data_next;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with special-register port and clear sequencer.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned SPECIAL_IDX = 15,
  parameter bit          ZERO_REG0   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sp_wr_en,
  input  logic [DATA_W-1:0]        sp_wr_data,
  output logic [DATA_W-1:0]        sp_rd_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SPECIAL_IDX);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  // Reset value of one entry: table value zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] init_entry(int unsigned idx);
    logic [DATA_W+15:0] wide;
    wide = '0;
    if (idx < INIT_DEPTH) wide[15:0] = INIT_TABLE[idx[3:0]];
    if (ZERO_REG0 && (idx == 0)) wide = '0;
    return wide[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  clr_state_e        state;
  logic [ADDR_W:0]   cnt;
  logic              gen_we, sp_we, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] sp_next;

  // Effective write strobes: writes are dropped while clearing or aimed at a hard-zero R0.
  always_comb begin
    gen_we = wr_en & ~busy;
    if (ZERO_REG0 && (wr_addr == '0)) gen_we = 1'b0;
    sp_we = sp_wr_en & ~busy;
    if (ZERO_REG0 && (SP_ADDR == '0)) sp_we = 1'b0;
    clr_we   = (state == CLEAR);
    clr_addr = cnt[ADDR_W-1:0];
    if (clr_we && (clr_addr == SP_ADDR)) sp_next = '0;
    else if (sp_we)                      sp_next = sp_wr_data;
    else if (gen_we && (wr_addr == SP_ADDR)) sp_next = wr_data;
    else                                 sp_next = mem[SP_ADDR];
  end

  // Array update; special write follows general so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= init_entry(i);
    end else begin
      if (gen_we) mem[wr_addr] <= wr_data;
      if (sp_we) mem[SP_ADDR] <= sp_wr_data;
      if (clr_we) mem[clr_addr] <= '0;
    end
  end

  // Clear sequencer: one entry per cycle, busy for exactly DEPTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Special register mirror, refreshed every cycle with write-first value.
  always_ff @(posedge clk) begin
    if (rst) sp_rd_data <= '0;
    else     sp_rd_data <= sp_next;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[k*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .SPECIAL_IDX (SPECIAL_IDX),
      .ZERO_REG0   (ZERO_REG0)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .addr       (port_addr),
      .arr_data   (mem[port_addr]),
      .gen_we     (gen_we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .sp_we      (sp_we),
      .sp_wr_data (sp_wr_data),
      .data       (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp against an array-level reference model.
module tb_reg_file_mp;

  logic        clk;
  logic        rst, rd_en, wr_en, sp_wr_en, clr_req, busy;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, sp_wr_data, sp_rd_data;

  logic        z_rst, z_rd_en, z_wr_en, z_sp_wr_en, z_clr_req, z_busy;
  logic [11:0] z_rd_addr;
  logic [47:0] z_rd_data;
  logic [3:0]  z_wr_addr;
  logic [15:0] z_wr_data, z_sp_wr_data, z_sp_rd_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] ref_init [16] = '{
    16'h0F00, 16'h0050, 16'hFF0F, 16'hF0FF, 16'h0040, 16'h0024, 16'h00FF, 16'hAAAA,
    16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000
  };
  logic [15:0] m_mem [16];
  logic [15:0] e_rd [2];
  logic [15:0] e_sp;
  logic        e_busy;
  int          m_pos;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sp_wr_en(sp_wr_en),
    .sp_wr_data(sp_wr_data), .sp_rd_data(sp_rd_data), .clr_req(clr_req), .busy(busy)
  );

  reg_file_mp #(.NUM_RD(3), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .rst(z_rst), .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .sp_wr_en(z_sp_wr_en),
    .sp_wr_data(z_sp_wr_data), .sp_rd_data(z_sp_rd_data), .clr_req(z_clr_req), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic cycle();
    logic [15:0] pre [16];
    pre = m_mem;
    if (rst) begin
      m_mem = ref_init;
      e_rd  = '{16'h0, 16'h0};
      e_sp  = 16'h0;
      m_pos = -1;
    end else if (m_pos >= 0) begin
      for (int k = 0; k < 2; k++) if (rd_en) e_rd[k] = pre[rd_addr[k*4 +: 4]];
      m_mem[m_pos] = 16'h0;
      m_pos++;
      if (m_pos == 16) m_pos = -1;
      e_sp = m_mem[15];
    end else begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (sp_wr_en) m_mem[15] = sp_wr_data;
      for (int k = 0; k < 2; k++) if (rd_en) e_rd[k] = m_mem[rd_addr[k*4 +: 4]];
      e_sp = m_mem[15];
      if (clr_req) m_pos = 0;
    end
    e_busy = (m_pos >= 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; rd_en = 0; wr_en = 0; sp_wr_en = 0; clr_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd_data); end
    total++; if (sp_rd_data !== 16'h0) begin bad++; $display("FAIL reset_sp got=%h want=0", sp_rd_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rd_en = 1; rd_addr = {4'd1, 4'd0};
    cycle();
    total++; if (rd_data !== 32'h0050_0F00) begin bad++; $display("FAIL reset_r0r1 got=%h want=00500f00", rd_data); end
    total++; if (sp_rd_data !== 16'h0) begin bad++; $display("FAIL reset_r15 got=%h want=0", sp_rd_data); end
    rd_addr = {4'd12, 4'd11};
    cycle();
    total++; if (rd_data !== 32'h0002_FFFF) begin bad++; $display("FAIL reset_r11r12 got=%h want=0002ffff", rd_data); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 1; wr_addr = 4'd3; wr_data = 16'h1234; rd_en = 1; rd_addr = {4'd3, 4'd3};
    cycle();
    wr_en = 0;
    total++; if (rd_data !== 32'h1234_1234) begin bad++; $display("FAIL bypass got=%h want=12341234", rd_data); end
    rd_addr = {4'd0, 4'd3};
    cycle();
    total++; if (rd_data[15:0] !== 16'h1234) begin bad++; $display("FAIL bypass_later got=%h want=1234", rd_data[15:0]); end
  endtask

  task automatic test_special();
    idle_inputs();
    wr_en = 1; wr_addr = 4'd15; wr_data = 16'hAAAA; sp_wr_en = 1; sp_wr_data = 16'h5555;
    cycle();
    wr_en = 0; sp_wr_en = 0;
    total++; if (sp_rd_data !== 16'h5555) begin bad++; $display("FAIL sp_prio got=%h want=5555", sp_rd_data); end
    rd_en = 1; rd_addr = {4'd15, 4'd15};
    cycle();
    total++; if (rd_data !== 32'h5555_5555) begin bad++; $display("FAIL sp_r15 got=%h want=55555555", rd_data); end
    rd_en = 0; rd_addr = {4'd1, 4'd2};
    cycle();
    total++; if (rd_data !== 32'h5555_5555) begin bad++; $display("FAIL rd_hold got=%h want=55555555", rd_data); end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      rd_en      = $urandom_range(0, 3) != 0;
      rd_addr    = 8'($urandom);
      wr_en      = $urandom_range(0, 1) != 0;
      wr_addr    = 4'($urandom);
      wr_data    = 16'($urandom);
      sp_wr_en   = $urandom_range(0, 3) == 0;
      sp_wr_data = 16'($urandom);
      cycle();
      total++;
      if (rd_data !== {e_rd[1], e_rd[0]}) begin
        bad++; $display("FAIL rand_rd i=%0d got=%h want=%h", i, rd_data, {e_rd[1], e_rd[0]});
      end
      total++;
      if (sp_rd_data !== e_sp) begin
        bad++; $display("FAIL rand_sp i=%0d got=%h want=%h", i, sp_rd_data, e_sp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cnt;
    idle_inputs();
    wr_en = 1; wr_addr = 4'd2; wr_data = 16'h7777;
    cycle();
    wr_en = 0; clr_req = 1;
    cycle();
    clr_req = 0;
    cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cnt++;
      wr_en = (i == 8); wr_addr = 4'd2; wr_data = 16'hBEEF;
      sp_wr_en = (i == 9); sp_wr_data = 16'h1111;
      clr_req = (i == 3);
      rd_en = 1; rd_addr = 8'($urandom);
      cycle();
      total++;
      if (rd_data !== {e_rd[1], e_rd[0]} || busy !== e_busy) begin
        bad++; $display("FAIL clear_step i=%0d got=%h/%b want=%h/%b", i, rd_data, busy,
                        {e_rd[1], e_rd[0]}, e_busy);
      end
    end
    idle_inputs();
    total++; if (cnt != 16) begin bad++; $display("FAIL clear_len got=%0d want=16", cnt); end
    rd_en = 1;
    for (int r = 0; r < 16; r += 2) begin
      rd_addr = {4'(r + 1), 4'(r)};
      cycle();
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL cleared r=%0d got=%h want=0", r, rd_data); end
    end
    total++; if (sp_rd_data !== 16'h0) begin bad++; $display("FAIL cleared_sp got=%h want=0", sp_rd_data); end
  endtask

  task automatic test_mid_clear();
    idle_inputs();
    clr_req = 1;
    cycle();
    clr_req = 0;
    repeat (4) cycle();
    rst = 1;
    cycle();
    rst = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b want=0", busy); end
    rd_en = 1; rd_addr = {4'd7, 4'd7};
    cycle();
    total++; if (rd_data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL midclr_r7 got=%h want=aaaaaaaa", rd_data); end
  endtask

  task automatic test_zero_reg();
    z_rst = 1;
    @(posedge clk); #1;
    z_rst = 0;
    z_wr_en = 1; z_wr_addr = 4'd0; z_wr_data = 16'hFFFF;
    z_rd_en = 1; z_rd_addr = {4'd1, 4'd0, 4'd0};
    @(posedge clk); #1;
    z_wr_en = 0;
    total++; if (z_rd_data !== 48'h0050_0000_0000) begin bad++; $display("FAIL zero_bypass got=%h want=005000000000", z_rd_data); end
    @(posedge clk); #1;
    total++; if (z_rd_data !== 48'h0050_0000_0000) begin bad++; $display("FAIL zero_read got=%h want=005000000000", z_rd_data); end
  endtask

  initial begin
    idle_inputs();
    rd_addr = '0; wr_addr = '0; wr_data = '0; sp_wr_data = '0;
    m_mem = ref_init; e_rd = '{16'h0, 16'h0}; e_sp = '0; e_busy = 0; m_pos = -1;
    z_rst = 1; z_rd_en = 0; z_wr_en = 0; z_sp_wr_en = 0; z_clr_req = 0;
    z_rd_addr = '0; z_wr_addr = '0; z_wr_data = '0; z_sp_wr_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_special();
    test_random();
    test_clear();
    test_mid_clear();
    test_zero_reg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file. Successor to the 16x16 datapath register memory.
- Adds independent read and write enables, write-first bypass, a configurable read-port count and a dedicated special-register port (default R15, flags/link).
- Adds a multi-cycle clear sequencer.
- Sits between decode and ALU: it supplies operands and takes writeback data.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of general read ports (1..4).
- SPECIAL_IDX, 15, index of the register served by the special port.
- ZERO_REG0, 0, when 1, R0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- rd_en  in  1  read strobe for all general ports
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- wr_en  in  1  general write strobe
- wr_addr  in  ADDR_W  general write address
- wr_data  in  DATA_W  general write data
- sp_wr_en  in  1  special-register write strobe
- sp_wr_data  in  DATA_W  special-register write data
- sp_rd_data  out  DATA_W  registered copy of register SPECIAL_IDX
- clr_req  in  1  one-cycle request to zero the whole array
- busy  out  1  high while the clear sequencer runs

Behaviour:
- Reset (clk edge with rst=1):
  - Array loads INIT_TABLE: R0..R15 = 0F00,0050,FF0F,F0FF,0040,0024,00FF,AAAA,0000,0000,0000,FFFF,0002,0000,0000,0000.
  - Entries beyond 15 load 0. Values are truncated or zero-extended to DATA_W.
  - With ZERO_REG0=1, R0 loads 0.
  - rd_data=0, sp_rd_data=0, busy=0, FSM=IDLE, clear counter=0.
  - rst overrides every other input, including mid-clear.
- Writes:
  - The array updates on the clock edge.
  - General write when wr_en=1 and busy=0.
  - Special write to SPECIAL_IDX when sp_wr_en=1 and busy=0.
  - Both writes targeting SPECIAL_IDX in the same cycle: special port wins.
  - ZERO_REG0=1: writes to R0 are dropped.
- Reads:
  - Latency 1. With rd_en=1 at edge N, rd_data port k shows the addressed content after edge N.
  - rd_en=0: rd_data holds its previous value.
  - Write-first bypass: if port k's address matches a write committing in the same cycle, port k returns the new data. The same priority applies (special wins over general).
  - ZERO_REG0=1 and address 0: returns 0.
  - All ports are independent. Duplicate addresses are legal and return identical data.
- sp_rd_data:
  - Updates every cycle, independent of rd_en.
  - Carries the value of SPECIAL_IDX after this edge's writes (write-first).
- Clear FSM:
  - States IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1. The clear counter loads 0 and busy goes to 1 on the same edge.
  - In CLEAR, each edge writes 0 to array[counter] and increments the counter.
  - After entry DEPTH-1 is written: state -> IDLE and busy -> 0. busy is high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored.
  - While busy=1:
    - wr_en and sp_wr_en are dropped, not queued.
    - Reads remain legal and return the current array content, with no bypass.
    - Read data may therefore mix cleared and uncleared entries.
  - clr_req together with wr_en in IDLE: the write commits this edge, then the clear begins and erases it.
- Widths: the counter is ADDR_W+1 bits so that terminal detection does not wrap. No arithmetic is performed on data.

Decomposition:
- Shared package regfile_pkg holds:
  - INIT_TABLE (16 x 16-bit constant array).
  - FSM state enum {IDLE, CLEAR}.
  - Default DATA_W and ADDR_W constants.
- One natural sub-module: reg_file_rd_port, a single registered read port with bypass mux and zero-reg masking.
  - Instantiated NUM_RD times in a generate loop.
  - Port logic is identical for every index.

Test Plan:
- Reset values: assert rst for 1 cycle; read R0/R1 then R11/R12 -> rd_data = {0050,0F00} then {0002,FFFF}; sp_rd_data=0000.
- Write-first bypass: wr_en, wr_addr=3, wr_data=1234 with rd_en, rd_addr={3,3} on the same edge -> both ports read 1234 next cycle. A later read of R3 also returns 1234.
- Special-port priority: same cycle wr_en with wr_addr=15, wr_data=AAAA and sp_wr_en with sp_wr_data=5555 -> sp_rd_data=5555 next cycle; a read of R15 returns 5555.
- Clear sequence: pulse clr_req -> busy high exactly 16 cycles. A wr_en to R2 during busy is dropped. After busy falls, reads of every register return 0000.
- Reset mid-clear: assert rst on clear cycle 5 -> busy=0 next cycle; R7 reads AAAA (INIT_TABLE restored).
- Zero register: ZERO_REG0=1, NUM_RD=3; write R0=FFFF, then read {0,0,1} -> rd_data = {0050,0000,0000}.
